// File: rtl/invert_frame_arbiter.sv
// Round-robin frame arbiter sharing one sign-conditional two's-complement
// negation datapath between two sample requesters. An owner holds the
// datapath for a full frame of FRAME accepted samples; results leave on a
// registered stream tagged with source index and end-of-frame.
module invert_frame_arbiter #(
    parameter int unsigned W     = 32,
    parameter int unsigned FRAME = 1024,
    parameter int unsigned CW    = 10
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic [1:0]   iReq,
    input  logic [1:0]   iSign,
    input  logic [1:0]   iValid,
    input  logic [W-1:0] iData0,
    input  logic [W-1:0] iData1,
    output logic [1:0]   oGrant,
    output logic [1:0]   oReady,
    output logic         oValid,
    output logic [W-1:0] oData,
    output logic         oSrc,
    output logic         oLast,
    output logic         oBusy
);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic           last_served_q;
    logic           sign_q;
    logic           owner_q;
    logic [1:0]     grant_q;
    logic [1:0]     ready_q;
    logic           valid_q;
    logic [W-1:0]   data_q;
    logic           src_q;
    logic           last_q;
    logic           busy_q;

    logic           pick_d;
    logic [W-1:0]   sel_data;
    logic           accept;
    logic [W-1:0]   proc_d;
    logic           frame_end;

    // Arbitration winner, owner sample mux and the shared negation datapath.
    always_comb begin
        pick_d = 1'b0;
        if (iReq == 2'b11) begin
            // Tie goes to whoever was not served last.
            pick_d = ~last_served_q;
        end else begin
            pick_d = iReq[1] & ~iReq[0];
        end
        sel_data  = owner_q ? iData1 : iData0;
        accept    = (state_q == StStream) && iValid[owner_q];
        proc_d    = sign_q ? (~sel_data + W'(1)) : sel_data;
        frame_end = (cnt_q == CW'(FRAME - 1));
    end

    // Frame FSM with all outputs registered; reset wins over any request.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            last_served_q <= 1'b1;
            sign_q        <= 1'b0;
            owner_q       <= 1'b0;
            grant_q       <= 2'b00;
            ready_q       <= 2'b00;
            valid_q       <= 1'b0;
            data_q        <= '0;
            src_q         <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|iReq) begin
                        owner_q       <= pick_d;
                        last_served_q <= pick_d;
                        sign_q        <= iSign[pick_d];
                        cnt_q         <= '0;
                        grant_q       <= pick_d ? 2'b10 : 2'b01;
                        ready_q       <= pick_d ? 2'b10 : 2'b01;
                        busy_q        <= 1'b1;
                        state_q       <= StStream;
                    end
                end
                StStream: begin
                    if (accept) begin
                        valid_q <= 1'b1;
                        data_q  <= proc_d;
                        src_q   <= owner_q;
                        cnt_q   <= cnt_q + CW'(1);
                        if (frame_end) begin
                            last_q  <= 1'b1;
                            cnt_q   <= '0;
                            grant_q <= 2'b00;
                            ready_q <= 2'b00;
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign oGrant = grant_q;
    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oData  = data_q;
    assign oSrc   = src_q;
    assign oLast  = last_q;
    assign oBusy  = busy_q;

endmodule

// File: tb/tb_invert_frame_arbiter.sv
// Self-checking bench for invert_frame_arbiter: random stimulus scored
// against a transaction-level model (owner, samples remaining, phase).
module tb_invert_frame_arbiter;

    localparam int W     = 32;
    localparam int FRAME = 1024;
    localparam int CW    = 10;

    logic          iClk = 1'b0;
    logic          iRst;
    logic [1:0]    iReq;
    logic [1:0]    iSign;
    logic [1:0]    iValid;
    logic [W-1:0]  iData0;
    logic [W-1:0]  iData1;
    logic [1:0]    oGrant;
    logic [1:0]    oReady;
    logic          oValid;
    logic [W-1:0]  oData;
    logic          oSrc;
    logic          oLast;
    logic          oBusy;

    invert_frame_arbiter #(
        .W     (W),
        .FRAME (FRAME),
        .CW    (CW)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iReq   (iReq),
        .iSign  (iSign),
        .iValid (iValid),
        .iData0 (iData0),
        .iData1 (iData1),
        .oGrant (oGrant),
        .oReady (oReady),
        .oValid (oValid),
        .oData  (oData),
        .oSrc   (oSrc),
        .oLast  (oLast),
        .oBusy  (oBusy)
    );

    always #5 iClk = ~iClk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: phase 0 idle, 1 streaming, 2 final output shown.
    int          m_phase = 0;
    int          m_owner = 0;
    int          m_left = 0;
    int          m_last_served = 1;
    bit          m_sign = 0;
    logic [1:0]  e_grant = '0;
    logic        e_valid = 0, e_last = 0, e_busy = 0, e_src = 0;
    logic [31:0] e_data = '0;

    // Observation bookkeeping.
    int          cyc = 0;
    int          last_cyc = -1;
    bit          chk_gap = 0;
    logic [1:0]  prev_g = '0;
    int          n_out = 0, n_g0 = 0, n_last = 0;
    logic [31:0] got_data[$];
    int          grant_order[$];
    logic [31:0] bvals[3];

    task automatic model_step();
        logic [31:0] d;
        int g;
        if (iRst) begin
            m_phase = 0; m_left = 0; m_last_served = 1; m_sign = 0; m_owner = 0;
            e_grant = '0; e_valid = 0; e_last = 0; e_busy = 0; e_src = 0; e_data = '0;
        end else begin
            e_valid = 0;
            e_last  = 0;
            case (m_phase)
                0: if (iReq != 2'b00) begin
                    if (iReq == 2'b11) g = 1 - m_last_served;
                    else g = iReq[0] ? 0 : 1;
                    m_owner = g; m_last_served = g; m_sign = iSign[g];
                    m_left = FRAME; m_phase = 1;
                    e_grant = (g == 0) ? 2'b01 : 2'b10;
                    e_busy = 1;
                end
                1: if (iValid[m_owner]) begin
                    d = (m_owner == 1) ? iData1 : iData0;
                    e_valid = 1;
                    e_data = m_sign ? (32'd0 - d) : d;
                    e_src = m_owner[0];
                    m_left--;
                    if (m_left == 0) begin
                        e_last = 1; e_grant = '0; m_phase = 2;
                    end
                end
                default: begin
                    m_phase = 0; e_busy = 0;
                end
            endcase
        end
    endtask

    task automatic compare();
        cyc++;
        check_val("grant", 64'(oGrant), 64'(e_grant));
        check_val("ready", 64'(oReady), 64'(e_grant));
        check_val("valid", 64'(oValid), 64'(e_valid));
        check_val("last", 64'(oLast), 64'(e_last));
        check_val("busy", 64'(oBusy), 64'(e_busy));
        if (e_valid) begin
            check_val("data", 64'(oData), 64'(e_data));
            check_val("src", 64'(oSrc), 64'(e_src));
        end
        if (oValid) begin
            n_out++;
            got_data.push_back(oData);
        end
        if (oGrant == 2'b01) n_g0++;
        if (oLast) n_last++;
        if (oGrant != 2'b00 && prev_g == 2'b00) begin
            grant_order.push_back(int'(oGrant[1]));
            if (chk_gap && last_cyc >= 0) check_val("turnaround", 64'(cyc - last_cyc), 64'd2);
            last_cyc = -1;
        end
        if (oLast) last_cyc = cyc;
        prev_g = oGrant;
    endtask

    task automatic cycle();
        model_step();
        @(posedge iClk);
        @(negedge iClk);
        compare();
    endtask

    task automatic do_reset();
        iRst = 1; iReq = '0; iValid = '0;
        cycle();
        iRst = 0;
        last_cyc = -1;
    endtask

    // dmode: 0 random data, 1 boundary values first, 2 sample index as data.
    task automatic run(input int nframes, input logic [1:0] req, input logic [1:0] sign,
                       input int pct, input int dmode, input int gap_at, input int drop_at,
                       input int rst_at);
        int frames = 0;
        int guard = 0;
        int idx;
        int gap_left = 0;
        bit gap_done = 0;
        logic [31:0] d;
        logic [1:0] v;
        iReq = req;
        iSign = sign;
        while (frames < nframes && guard < FRAME * 4 * nframes) begin
            guard++;
            idx = (m_phase == 1) ? FRAME - m_left : 0;
            case (dmode)
                1: d = (idx < 3) ? bvals[idx] : $urandom;
                2: d = idx;
                default: d = $urandom;
            endcase
            iData0 = d;
            iData1 = d;
            v = 2'($urandom);
            if (m_phase == 1) begin
                if (gap_at >= 0 && idx == gap_at && !gap_done) begin
                    gap_left = 5; gap_done = 1;
                end
                if (gap_left > 0) begin
                    v[m_owner] = 1'b0; gap_left--;
                end else begin
                    v[m_owner] = ($urandom_range(99) < pct);
                end
                if (drop_at >= 0 && idx >= drop_at) iReq = 2'b00;
            end
            iValid = v;
            if (rst_at >= 0 && m_phase == 1 && idx == rst_at) begin
                iRst = 1; iReq = 2'b11;
            end
            cycle();
            if (iRst) begin
                iRst = 0; iReq = '0; iValid = '0;
                return;
            end
            if (e_last) frames++;
        end
        if (frames < nframes) check_val("timeout", 64'(frames), 64'(nframes));
        iReq = '0;
        iValid = '0;
        cycle();
        cycle();
    endtask

    initial begin
        bvals[0] = 32'h0000_0000;
        bvals[1] = 32'h8000_0000;
        bvals[2] = 32'h7FFF_FFFF;
        iRst = 1; iReq = '0; iSign = '0; iValid = '0; iData0 = '0; iData1 = '0;
        do_reset();
        do_reset();
        check_val("rst_data", 64'(oData), 64'd0);
        check_val("rst_busy", 64'(oBusy), 64'd0);

        // Continuous index ramp, negated, requester 0 only.
        n_out = 0; n_g0 = 0; n_last = 0; got_data.delete();
        run(1, 2'b01, 2'b01, 100, 2, -1, -1, -1);
        check_val("ramp_count", 64'(n_out), 64'd1024);
        check_val("ramp_first", 64'(got_data[0]), 64'h0);
        check_val("ramp_second", 64'(got_data[1]), 64'hFFFF_FFFF);
        check_val("ramp_final", 64'(got_data[1023]), 64'hFFFF_FC01);
        check_val("ramp_grant_cycles", 64'(n_g0), 64'd1024);
        check_val("ramp_last_count", 64'(n_last), 64'd1);

        // Boundary values, negated then passed through.
        got_data.delete();
        run(1, 2'b01, 2'b01, 100, 1, -1, -1, -1);
        check_val("neg_zero", 64'(got_data[0]), 64'h0000_0000);
        check_val("neg_min", 64'(got_data[1]), 64'h8000_0000);
        check_val("neg_max", 64'(got_data[2]), 64'h8000_0001);
        got_data.delete();
        run(1, 2'b10, 2'b00, 100, 1, -1, -1, -1);
        check_val("pass_zero", 64'(got_data[0]), 64'h0000_0000);
        check_val("pass_min", 64'(got_data[1]), 64'h8000_0000);
        check_val("pass_max", 64'(got_data[2]), 64'h7FFF_FFFF);

        // Both requesting for three frames: alternation and turnaround.
        do_reset();
        grant_order.delete();
        chk_gap = 1;
        run(3, 2'b11, 2'($urandom), 80, 0, -1, -1, -1);
        chk_gap = 0;
        check_val("order_len", 64'(grant_order.size()), 64'd3);
        check_val("order0", 64'(grant_order[0]), 64'd0);
        check_val("order1", 64'(grant_order[1]), 64'd1);
        check_val("order2", 64'(grant_order[2]), 64'd0);

        // Valid gap plus request drop; non-owner valid toggles randomly.
        do_reset();
        n_out = 0;
        run(1, 2'b01, 2'($urandom), 90, 0, 40, 100, -1);
        check_val("gap_count", 64'(n_out), 64'd1024);

        // Reset mid-frame coinciding with a double request.
        do_reset();
        n_last = 0;
        run(1, 2'b01, 2'b01, 100, 0, -1, -1, 500);
        check_val("midrst_grant", 64'(oGrant), 64'd0);
        check_val("midrst_valid", 64'(oValid), 64'd0);
        check_val("midrst_data", 64'(oData), 64'd0);
        check_val("midrst_busy", 64'(oBusy), 64'd0);
        check_val("midrst_nolast", 64'(n_last), 64'd0);
        iReq = 2'b11;
        cycle();
        check_val("post_rst_grant", 64'(oGrant), 64'b01);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
